// File: rtl/logic_cell_cfg_loader.sv
// Serial loader for the logic-cell LUT configuration bank.
// It decodes framed MSB-first words (sync, addr, data, checksum) and commits each valid word to its cell.
module logic_cell_cfg_loader #(
    parameter int          NUM_CELLS = 4,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic                     QCK,
    input  logic                     QRTN,
    input  logic                     CFG_DI,
    input  logic                     CFG_EN,
    input  logic                     ERR_CLR,
    output logic [16*NUM_CELLS-1:0]  lFragBitInfo,
    output logic                     CFG_WE,
    output logic [7:0]               CFG_ADDR,
    output logic                     CFG_BUSY,
    output logic                     CFG_ERR
);

    typedef enum logic [1:0] {S_HUNT, S_ADDR, S_DATA, S_CHK} state_t;

    state_t                        state, state_nxt;
    logic [6:0]                    win;
    logic [3:0]                    cnt;
    logic [7:0]                    addr_sr;
    logic [15:0]                   data_sr;
    logic [6:0]                    chk_sr;
    logic [NUM_CELLS-1:0][15:0]    bank;

    logic [7:0]                    win_nxt;
    logic [7:0]                    chk_word;
    logic                          addr_ok;
    logic                          commit;
    logic                          reject;

    assign win_nxt      = {win, CFG_DI};
    assign chk_word     = {chk_sr, CFG_DI};
    assign addr_ok      = ({1'b0, addr_sr} < 9'(NUM_CELLS));
    assign lFragBitInfo = bank;
    assign CFG_BUSY     = (state != S_HUNT);

    always_ff @(posedge QCK or negedge QRTN) begin
        if (!QRTN) state <= S_HUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        reject    = 1'b0;
        if (CFG_EN) begin
            case (state)
                S_HUNT: if (win_nxt == SYNC) state_nxt = S_ADDR;
                S_ADDR: if (cnt == 4'd7)     state_nxt = S_DATA;
                S_DATA: if (cnt == 4'd15)    state_nxt = S_CHK;
                S_CHK: begin
                    if (cnt == 4'd7) begin
                        state_nxt = S_HUNT;
                        // Checksum covers the address byte and both data bytes.
                        if (chk_word == (addr_sr ^ data_sr[15:8] ^ data_sr[7:0]) && addr_ok)
                            commit = 1'b1;
                        else
                            reject = 1'b1;
                    end
                end
                default: state_nxt = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge QCK or negedge QRTN) begin
        if (!QRTN) begin
            win      <= '0;
            cnt      <= '0;
            addr_sr  <= '0;
            data_sr  <= '0;
            chk_sr   <= '0;
            bank     <= '0;
            CFG_WE   <= 1'b0;
            CFG_ADDR <= '0;
            CFG_ERR  <= 1'b0;
        end else begin
            CFG_WE <= commit;
            if (reject)       CFG_ERR <= 1'b1;
            else if (ERR_CLR) CFG_ERR <= 1'b0;
            if (commit) CFG_ADDR <= addr_sr;
            for (int k = 0; k < NUM_CELLS; k++)
                if (commit && addr_sr == 8'(k)) bank[k] <= data_sr;
            if (CFG_EN) begin
                case (state)
                    // Window is left zeroed on exit so the next hunt needs 8 fresh bits.
                    S_HUNT: begin
                        win <= (state_nxt == S_ADDR) ? 7'd0 : win_nxt[6:0];
                        cnt <= '0;
                    end
                    S_ADDR: begin
                        addr_sr <= {addr_sr[6:0], CFG_DI};
                        cnt     <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                    end
                    S_DATA: begin
                        data_sr <= {data_sr[14:0], CFG_DI};
                        cnt     <= (cnt == 4'd15) ? 4'd0 : cnt + 4'd1;
                    end
                    S_CHK: begin
                        chk_sr <= chk_word[6:0];
                        cnt    <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_logic_cell_cfg_loader.sv
// Directed bench for logic_cell_cfg_loader: frames with hand-computed checksums and expected bank contents.
module tb_logic_cell_cfg_loader;

    logic        QCK = 1'b0;
    logic        QRTN = 1'b0;
    logic        CFG_DI = 1'b0;
    logic        CFG_EN = 1'b0;
    logic        ERR_CLR = 1'b0;
    logic [63:0] lFragBitInfo;
    logic        CFG_WE;
    logic [7:0]  CFG_ADDR;
    logic        CFG_BUSY;
    logic        CFG_ERR;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int we_cnt = 0;
    int we_last = 0;
    int we_prev = 0;
    int we_base = 0;

    logic_cell_cfg_loader #(.NUM_CELLS(4), .SYNC(8'hA5)) dut (
        .QCK(QCK), .QRTN(QRTN), .CFG_DI(CFG_DI), .CFG_EN(CFG_EN), .ERR_CLR(ERR_CLR),
        .lFragBitInfo(lFragBitInfo), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
        .CFG_BUSY(CFG_BUSY), .CFG_ERR(CFG_ERR)
    );

    always #5 QCK = ~QCK;
    always @(posedge QCK) cyc++;
    always @(negedge QCK) if (CFG_WE) begin
        we_cnt++;
        we_prev = we_last;
        we_last = cyc;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        CFG_EN = 1'b0;
        repeat (n) @(negedge QCK);
    endtask

    // Sends bits lo..hi (0 = first/MSB) of a 40-bit frame; gm[i] inserts a 3-cycle gap before bit i.
    task automatic send_bits(input logic [39:0] f, input int lo, input int hi, input logic [39:0] gm);
        for (int i = lo; i <= hi; i++) begin
            if (gm[i]) idle(3);
            CFG_EN = 1'b1;
            CFG_DI = f[39-i];
            @(negedge QCK);
        end
    endtask

    function automatic logic [39:0] fr(input logic [7:0] a, input logic [15:0] d, input logic [7:0] c);
        return {8'hA5, a, d, c};
    endfunction

    initial begin
        logic [39:0] f;
        logic [39:0] gm;

        // Reset state
        repeat (3) @(negedge QCK);
        check("rst_bank", lFragBitInfo, 64'h0);
        check("rst_we",   {63'b0, CFG_WE}, 64'h0);
        check("rst_addr", {56'b0, CFG_ADDR}, 64'h0);
        check("rst_busy", {63'b0, CFG_BUSY}, 64'h0);
        check("rst_err",  {63'b0, CFG_ERR}, 64'h0);
        QRTN = 1'b1;
        idle(2);

        // 1: valid frame to cell 2
        f = fr(8'h02, 16'h1234, 8'h24);
        we_base = we_cnt;
        send_bits(f, 0, 7, 40'b0);
        check("t1_busy_after_sync", {63'b0, CFG_BUSY}, 64'h1);
        send_bits(f, 8, 39, 40'b0);
        check("t1_we",   {63'b0, CFG_WE}, 64'h1);
        check("t1_addr", {56'b0, CFG_ADDR}, 64'h2);
        check("t1_bank", lFragBitInfo, 64'h0000_1234_0000_0000);
        check("t1_busy", {63'b0, CFG_BUSY}, 64'h0);
        idle(1);
        check("t1_we_drop", {63'b0, CFG_WE}, 64'h0);
        check("t1_we_cnt",  64'(we_cnt - we_base), 64'h1);
        check("t1_err",     {63'b0, CFG_ERR}, 64'h0);

        // 2: bad checksum, then clear
        we_base = we_cnt;
        send_bits(fr(8'h01, 16'hBEEF, 8'h00), 0, 39, 40'b0);
        check("t2_we",   {63'b0, CFG_WE}, 64'h0);
        check("t2_err",  {63'b0, CFG_ERR}, 64'h1);
        check("t2_busy", {63'b0, CFG_BUSY}, 64'h0);
        idle(1);
        check("t2_bank", lFragBitInfo, 64'h0000_1234_0000_0000);
        check("t2_we_cnt", 64'(we_cnt - we_base), 64'h0);
        ERR_CLR = 1'b1;
        @(negedge QCK);
        ERR_CLR = 1'b0;
        check("t2_err_clr", {63'b0, CFG_ERR}, 64'h0);

        // 3: out-of-range address with good checksum; ERR_CLR held so set must win
        we_base = we_cnt;
        ERR_CLR = 1'b1;
        send_bits(fr(8'h07, 16'h00FF, 8'hF8), 0, 39, 40'b0);
        ERR_CLR = 1'b0;
        check("t3_err_set_wins", {63'b0, CFG_ERR}, 64'h1);
        check("t3_addr", {56'b0, CFG_ADDR}, 64'h2);
        idle(1);
        check("t3_bank", lFragBitInfo, 64'h0000_1234_0000_0000);
        check("t3_we_cnt", 64'(we_cnt - we_base), 64'h0);
        ERR_CLR = 1'b1;
        @(negedge QCK);
        ERR_CLR = 1'b0;

        // 4: noise bits then a gapped frame to cell 0
        we_base = we_cnt;
        send_bits({37'b0, 3'b110}, 37, 39, 40'b0);
        gm = '0;
        gm[5] = 1'b1; gm[12] = 1'b1; gm[20] = 1'b1; gm[29] = 1'b1; gm[36] = 1'b1;
        send_bits(fr(8'h00, 16'hFFFF, 8'h00), 0, 39, gm);
        check("t4_addr", {56'b0, CFG_ADDR}, 64'h0);
        idle(2);
        check("t4_bank", lFragBitInfo, 64'h0000_1234_0000_FFFF);
        check("t4_we_cnt", 64'(we_cnt - we_base), 64'h1);

        // 5: back-to-back frames
        we_base = we_cnt;
        send_bits(fr(8'h01, 16'h0F0F, 8'h01), 0, 39, 40'b0);
        send_bits(fr(8'h03, 16'hAAAA, 8'h03), 0, 39, 40'b0);
        check("t5_addr", {56'b0, CFG_ADDR}, 64'h3);
        idle(2);
        check("t5_we_cnt", 64'(we_cnt - we_base), 64'h2);
        check("t5_spacing", 64'(we_last - we_prev), 64'd40);
        check("t5_bank", lFragBitInfo, 64'hAAAA_1234_0F0F_FFFF);
        check("t5_err", {63'b0, CFG_ERR}, 64'h0);

        // 6: reset after the 20th bit
        we_base = we_cnt;
        f = fr(8'h02, 16'h0000, 8'h02);
        send_bits(f, 0, 19, 40'b0);
        CFG_EN = 1'b0;
        QRTN = 1'b0;
        #1;
        check("t6_rst_bank", lFragBitInfo, 64'h0);
        check("t6_rst_busy", {63'b0, CFG_BUSY}, 64'h0);
        check("t6_rst_addr", {56'b0, CFG_ADDR}, 64'h0);
        check("t6_rst_err",  {63'b0, CFG_ERR}, 64'h0);
        @(negedge QCK);
        QRTN = 1'b1;
        send_bits(f, 20, 39, 40'b0);
        idle(2);
        check("t6_tail_we_cnt", 64'(we_cnt - we_base), 64'h0);
        check("t6_tail_bank", lFragBitInfo, 64'h0);
        check("t6_tail_busy", {63'b0, CFG_BUSY}, 64'h0);
        send_bits(fr(8'h03, 16'h1111, 8'h03), 0, 39, 40'b0);
        check("t6_we",   {63'b0, CFG_WE}, 64'h1);
        check("t6_addr", {56'b0, CFG_ADDR}, 64'h3);
        check("t6_bank", lFragBitInfo, 64'h1111_0000_0000_0000);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
